seg_display_ctrl: RTL

Parametrised multiplexed seven-segment display controller that takes a binary value over a valid/ready handshake and drives common-anode digits. It supports decimal mode (sequential double-dabble binary-to-BCD) and hex mode, detects overflow, and scans NUM_DIGITS digits at a programmable refresh rate. It sits between the CPU result register and the board display, and is the generalised successor of the fixed 16-bit, 4-digit BCD display driver.

---
 rtl/seg_display_ctrl.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
//
// Multiplexed seven-segment display controller for common-anode digits.
// A binary value is accepted over a valid/ready handshake, converted either to
// BCD (sequential double-dabble, one bit per clock) or split into hex nibbles,
// and then scanned across NUM_DIGITS digits at a programmable refresh rate.
//
// Parameters:
//   DATA_W      width of the input value (4..32)
//   NUM_DIGITS  number of physical digits (1..8)
//   REFRESH_DIV clock cycles each digit stays lit (>=2)
//
// Ports:
//   clock     system clock
//   reset     synchronous, active-high reset
//   in_valid  value/mode presented
//   in_ready  controller can accept a value (state is IDLE)
//   in_data   binary value to display
//   in_hex    1 = hex mode, 0 = decimal mode, sampled with in_data
//   busy      conversion in progress (inverse of in_ready)
//   overflow  shown value does not fit in NUM_DIGITS digits
//   an        digit enables, active low, one-hot; an[0] is the rightmost digit
//   seg       segments {g,f,e,d,c,b,a}, active low
//   dp        decimal point, active low
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, zero digits above the most significant non-zero digit are
//   blanked (digit 0 is never blanked, overflow dashes are never blanked).
//   When undefined, every digit always shows its value.
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_hex,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // 10^n computed at elaboration time; 10^8 still fits comfortably in 64 bits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  // Active-low segment pattern for one hex/BCD digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  bin_reg;
  logic               hex_reg;
  logic               ovf_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   shown;
  logic               shown_hex;

  logic [PRE_W-1:0]   pre_cnt;
  logic [IDX_W-1:0]   idx;

  logic [63:0]        data_wide;
  logic               ovf_next;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   hex_digits;

  logic               pre_last;
  logic [IDX_W-1:0]   idx_next;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]         cur_digit;
  logic               cur_blank;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]         seg_next;
  logic               dp_next;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  // Overflow is decided once, at acceptance, from the raw binary value:
  // decimal overflows above 10^N-1, hex overflows if any bit beyond the
  // available nibbles is set.
  always_comb begin
    data_wide = 64'(in_data);
    if (in_hex) begin
      ovf_next = (data_wide >> BCD_W) != 64'd0;
    end else begin
      ovf_next = data_wide > DEC_MAX;
    end
  end

  // Double-dabble correction: any BCD digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_reg[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
      end
    end
  end

  // Hex digits are the low nibbles of the value, zero-extended when the
  // value is narrower than the display.
  assign hex_digits = BCD_W'(bin_reg);

  // Control FSM. The conversion works on private registers; the shown-digit
  // register and overflow flag change together in UPDATE so the scan never
  // sees a half-converted value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bin_reg   <= '0;
      hex_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
      shown     <= '0;
      shown_hex <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg <= in_data;
            hex_reg <= in_hex;
            ovf_reg <= ovf_next;
            bcd_reg <= '0;
            bit_cnt <= '0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          if (hex_reg) begin
            bcd_reg <= hex_digits;
            state   <= UPDATE;
          end else begin
            // Bits pushed out of the top of the BCD register are lost; the
            // overflow flag already covers every value where that happens.
            bcd_reg <= (bcd_adj << 1) | BCD_W'(bin_reg[DATA_W-1]);
            bin_reg <= bin_reg << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          shown     <= bcd_reg;
          shown_hex <= hex_reg;
          overflow  <= ovf_reg;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Next scan position: the prescaler wrap advances the digit index.
  always_comb begin
    pre_last = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
    idx_next = idx;
    if (pre_last) begin
      if (idx == IDX_W'(NUM_DIGITS - 1)) begin
        idx_next = '0;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; zeros are blanked until the
  // first non-zero digit is seen. Digit 0 is excluded so zero shows as '0'.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (shown[4*k +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen) begin
        blank_mask[k] = 1'b1;
      end
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Select the digit that will be lit after this edge and build its outputs
  // so that an, seg and dp all change on the same edge.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        cur_digit  = shown[4*k +: 4];
        cur_blank  = blank_mask[k];
        an_next[k] = 1'b0;
      end
    end

    if (overflow) begin
      seg_next = SEG_DASH;
    end else if (cur_blank) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = seg_pattern(cur_digit);
    end

    dp_next = ~(shown_hex && (idx_next == '0));
  end

  // Scan registers: prescaler, digit index and the registered drive outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt <= '0;
      idx     <= '0;
      an      <= ~NUM_DIGITS'(1);
      seg     <= 7'b1000000;
      dp      <= 1'b1;
    end else begin
      pre_cnt <= pre_last ? '0 : pre_cnt + PRE_W'(1);
      idx     <= idx_next;
      an      <= an_next;
      seg     <= seg_next;
      dp      <= dp_next;
    end
  end

endmodule
